// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared constants for the two-port memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;
    localparam int   DEPTH_DEFAULT = 4;
    localparam logic ID_IC         = 1'b0;
    localparam logic ID_DC         = 1'b1;
endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
// ============================================================================
// Module : arb_id_fifo
// Brief  : In-order FIFO of 1-bit requester IDs for outstanding reads.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_push_id,
    input  logic                     i_pop,
    output logic                     o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the head slot, so a push is legal even when full.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one memory port between I$ and D$.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ic_ren,
    input  logic        i_ic_wen,
    input  logic [31:0] i_ic_addr,
    input  logic [31:0] i_ic_wdata,
    output logic        o_ic_ready,
    output logic        o_ic_valid,
    output logic [31:0] o_ic_rdata,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_addr,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic        o_dc_valid,
    output logic [31:0] o_dc_rdata,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err
);
    logic                   w_ic_bad, w_dc_bad;
    logic                   w_ic_ok, w_dc_ok;
    logic                   w_pop, w_stray, w_can_read;
    logic                   w_gnt_vld, w_gnt_id, w_gnt_ren, w_accept;
    logic                   w_head, w_full, w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   r_last_id, r_hold, r_hold_id, r_err;

    assign w_ic_bad   = i_ic_ren & i_ic_wen;
    assign w_dc_bad   = i_dc_ren & i_dc_wen;
    assign w_pop      = i_rst_n & i_mem_valid & ~w_empty;
    assign w_stray    = i_mem_valid & (w_count == '0);
    assign w_can_read = ~w_full | w_pop;

    // A blocked reader is not eligible, so a writer can use the port while the FIFO is full.
    assign w_ic_ok = i_rst_n & ((i_ic_wen & ~i_ic_ren) | (i_ic_ren & ~i_ic_wen & w_can_read));
    assign w_dc_ok = i_rst_n & ((i_dc_wen & ~i_dc_ren) | (i_dc_ren & ~i_dc_wen & w_can_read));

    always_comb begin
        w_gnt_vld = w_ic_ok | w_dc_ok;
        w_gnt_id  = ID_IC;
        if (r_hold && ((r_hold_id == ID_DC) ? w_dc_ok : w_ic_ok)) begin
            w_gnt_id = r_hold_id;
        end else if (w_ic_ok && w_dc_ok) begin
            w_gnt_id = ~r_last_id;
        end else if (w_dc_ok) begin
            w_gnt_id = ID_DC;
        end
    end

    assign w_gnt_ren = (w_gnt_id == ID_DC) ? i_dc_ren : i_ic_ren;
    assign w_accept  = w_gnt_vld & i_mem_ready;

    always_comb begin
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt_vld) begin
            if (w_gnt_id == ID_DC) begin
                o_mem_ren   = i_dc_ren;
                o_mem_wen   = i_dc_wen;
                o_mem_addr  = i_dc_addr;
                o_mem_wdata = i_dc_wdata;
            end else begin
                o_mem_ren   = i_ic_ren;
                o_mem_wen   = i_ic_wen;
                o_mem_addr  = i_ic_addr;
                o_mem_wdata = i_ic_wdata;
            end
        end
    end

    assign o_ic_ready = w_accept & (w_gnt_id == ID_IC);
    assign o_dc_ready = w_accept & (w_gnt_id == ID_DC);
    assign o_ic_valid = w_pop & (w_head == ID_IC);
    assign o_dc_valid = w_pop & (w_head == ID_DC);
    assign o_ic_rdata = o_ic_valid ? i_mem_rdata : '0;
    assign o_dc_rdata = o_dc_valid ? i_mem_rdata : '0;
    assign o_err      = r_err;

    arb_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (w_accept & w_gnt_ren),
        .i_push_id (w_gnt_id),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_id <= ID_IC;
            r_hold    <= 1'b0;
            r_hold_id <= ID_IC;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_id <= w_gnt_id;
            end
            r_hold    <= w_gnt_vld & ~i_mem_ready;
            r_hold_id <= w_gnt_id;
            r_err     <= r_err | w_ic_bad | w_dc_bad | w_stray;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen;
    logic [31:0] i_ic_addr, i_ic_wdata, i_dc_addr, i_dc_wdata;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
    logic [31:0] o_ic_rdata, o_dc_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen, o_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: outstanding read owners in order, last winner, stall hold, error flag.
    bit m_q[$];
    bit m_last;
    bit m_hold;
    bit m_hold_id;
    bit m_err;

    mem_arbiter #(.DEPTH(DEPTH)) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ic_ren    (i_ic_ren),
        .i_ic_wen    (i_ic_wen),
        .i_ic_addr   (i_ic_addr),
        .i_ic_wdata  (i_ic_wdata),
        .o_ic_ready  (o_ic_ready),
        .o_ic_valid  (o_ic_valid),
        .o_ic_rdata  (o_ic_rdata),
        .i_dc_ren    (i_dc_ren),
        .i_dc_wen    (i_dc_wen),
        .i_dc_addr   (i_dc_addr),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_ready  (o_dc_ready),
        .o_dc_valid  (o_dc_valid),
        .o_dc_rdata  (o_dc_rdata),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit icr, input bit icw, input logic [31:0] ica, input logic [31:0] icd,
                         input bit dcr, input bit dcw, input logic [31:0] dca, input logic [31:0] dcd,
                         input bit rdy, input bit vld, input logic [31:0] rd);
        i_ic_ren = icr; i_ic_wen = icw; i_ic_addr = ica; i_ic_wdata = icd;
        i_dc_ren = dcr; i_dc_wen = dcw; i_dc_addr = dca; i_dc_wdata = dcd;
        i_mem_ready = rdy; i_mem_valid = vld; i_mem_rdata = rd;
    endtask

    task automatic idle(input bit vld, input logic [31:0] rd);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, vld, rd);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last    = ID_IC;
        m_hold    = 1'b0;
        m_hold_id = ID_IC;
        m_err     = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mren"},  32'(o_mem_ren), 0);
        check({tag, "_mwen"},  32'(o_mem_wen), 0);
        check({tag, "_maddr"}, o_mem_addr, 0);
        check({tag, "_mwd"},   o_mem_wdata, 0);
        check({tag, "_rdy"},   {30'd0, o_ic_ready, o_dc_ready}, 0);
        check({tag, "_vld"},   {30'd0, o_ic_valid, o_dc_valid}, 0);
        check({tag, "_icrd"},  o_ic_rdata, 0);
        check({tag, "_dcrd"},  o_dc_rdata, 0);
        check({tag, "_err"},   32'(o_err), 0);
    endtask

    // Called just after a negedge with inputs applied: checks outputs, clocks, updates model.
    task automatic step();
        bit          pop, can_rd, ic_ok, dc_ok, gv, gid, acc, gren;
        bit          e_ren, e_wen;
        logic [31:0] e_addr, e_wd;
        int          cnt;
        #1;
        cnt    = m_q.size();
        pop    = i_mem_valid && (cnt > 0);
        can_rd = (cnt < DEPTH) || pop;
        ic_ok  = (i_ic_wen && !i_ic_ren) || (i_ic_ren && !i_ic_wen && can_rd);
        dc_ok  = (i_dc_wen && !i_dc_ren) || (i_dc_ren && !i_dc_wen && can_rd);
        gv     = ic_ok || dc_ok;
        if (m_hold && (m_hold_id == ID_DC ? dc_ok : ic_ok)) gid = m_hold_id;
        else if (ic_ok && dc_ok)                            gid = (m_last == ID_IC) ? ID_DC : ID_IC;
        else                                                gid = dc_ok ? ID_DC : ID_IC;
        e_ren = 0; e_wen = 0; e_addr = 0; e_wd = 0; gren = 0;
        if (gv) begin
            gren   = (gid == ID_DC) ? i_dc_ren : i_ic_ren;
            e_ren  = gren;
            e_wen  = !gren;
            e_addr = (gid == ID_DC) ? i_dc_addr : i_ic_addr;
            e_wd   = (gid == ID_DC) ? i_dc_wdata : i_ic_wdata;
        end
        acc = gv && i_mem_ready;
        check("mem_addr",  o_mem_addr, e_addr);
        check("mem_wdata", o_mem_wdata, e_wd);
        check("mem_ren",   32'(o_mem_ren), 32'(e_ren));
        check("mem_wen",   32'(o_mem_wen), 32'(e_wen));
        check("ic_ready",  32'(o_ic_ready), 32'(acc && gid == ID_IC));
        check("dc_ready",  32'(o_dc_ready), 32'(acc && gid == ID_DC));
        check("ic_valid",  32'(o_ic_valid), 32'(pop && m_q[0] == ID_IC));
        check("dc_valid",  32'(o_dc_valid), 32'(pop && m_q[0] == ID_DC));
        check("ic_rdata",  o_ic_rdata, (pop && m_q[0] == ID_IC) ? i_mem_rdata : 32'd0);
        check("dc_rdata",  o_dc_rdata, (pop && m_q[0] == ID_DC) ? i_mem_rdata : 32'd0);
        check("err",       32'(o_err), 32'(m_err));
        @(posedge i_clk);
        m_err = m_err || (i_ic_ren && i_ic_wen) || (i_dc_ren && i_dc_wen) || (i_mem_valid && cnt == 0);
        if (pop) void'(m_q.pop_front());
        if (acc && gren) m_q.push_back(gid);
        if (acc) m_last = gid;
        m_hold    = gv && !i_mem_ready;
        m_hold_id = gid;
        @(negedge i_clk);
    endtask

    initial begin
        int r;
        // Reset with every input active: outputs must still be all zero.
        i_rst_n = 1'b0;
        drive(1, 0, 32'h11, 32'h22, 0, 1, 32'h33, 32'h44, 1, 1, 32'h55);
        repeat (2) @(negedge i_clk);
        #1 check_zero("rst");
        model_reset();
        idle(0, 0);
        i_rst_n = 1'b1;
        step();

        // Contention: DC wins first, then IC; responses return in accept order.
        drive(1, 0, 32'h100, 0, 1, 0, 32'h200, 0, 1, 0, 0);
        #1 check("cont_first_addr", o_mem_addr, 32'h200);
        step();
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 check("cont_second_addr", o_mem_addr, 32'h100);
        step();
        idle(1, 32'hD0D0_0000);
        #1 check("cont_d0_dc", o_dc_rdata, 32'hD0D0_0000);
        step();
        idle(1, 32'hD1D1_1111);
        #1 check("cont_d1_ic", o_ic_rdata, 32'hD1D1_1111);
        step();

        // Stall: DC write held stable for 3 not-ready cycles, ready pulses once.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, i == 3, 0, 0);
            #1;
            check("stall_addr",  o_mem_addr, 32'h40);
            check("stall_wdata", o_mem_wdata, 32'hDEAD_BEEF);
            check("stall_ready", 32'(o_dc_ready), 32'(i == 3));
            step();
        end

        // Full: four IC reads, then blocked read alongside an accepted DC write.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 32'h1000 + i, 0, 0, 0, 0, 0, 1, 0, 0);
            step();
        end
        drive(1, 0, 32'h2000, 0, 0, 1, 32'h3000, 32'hCAFE, 1, 0, 0);
        #1;
        check("full_ic_blocked", 32'(o_ic_ready), 0);
        check("full_dc_write",   32'(o_dc_ready), 1);
        step();
        drive(1, 0, 32'h2000, 0, 0, 0, 0, 0, 1, 1, 32'hF00D);
        #1 check("full_pop_push", 32'(o_ic_ready), 1);
        step();
        check("full_count", 32'(u_dut.u_id_fifo.o_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            idle(1, 32'hE000 + i);
            step();
        end

        // Wrap: alternating reads, each answered the following cycle.
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10 && k % 2 == 0, 0, 32'h500 + k, 0, k < 10 && k % 2 == 1, 0, 32'h600 + k, 0,
                  1, k > 0, 32'hA000_0000 + k - 1);
            if (k > 0) begin
                #1;
                if ((k - 1) % 2 == 0) check("wrap_ic_rdata", o_ic_rdata, 32'hA000_0000 + k - 1);
                else                  check("wrap_dc_rdata", o_dc_rdata, 32'hA000_0000 + k - 1);
            end
            step();
        end
        check("wrap_no_err", 32'(o_err), 0);

        // Random legal traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int a, b;
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            drive(a == 1, a == 2, $urandom, $urandom, b == 1, b == 2, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, m_q.size() > 0 && $urandom_range(0, 9) < 4, $urandom);
            step();
        end
        for (int n = 0; n < 2 * DEPTH && m_q.size() > 0; n++) begin
            idle(1, $urandom);
            step();
        end
        check("drain_empty", 32'(u_dut.u_id_fifo.o_count), 0);

        // Stray response with an empty FIFO: no valid, sticky error.
        idle(1, 32'hBAD0_0001);
        #1 check("stray_no_valid", {30'd0, o_ic_valid, o_dc_valid}, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(0, 0);
            #1 check("stray_err_sticky", 32'(o_err), 1);
            step();
        end

        // Reset mid-operation with two reads outstanding.
        drive(1, 0, 32'h700, 0, 1, 0, 32'h800, 0, 1, 0, 0);
        step();
        drive(1, 0, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(1, 0, 32'h900, 32'h1, 0, 1, 32'hA00, 32'h2, 1, 1, 32'h1234);
        #2 i_rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge i_clk);
        model_reset();
        idle(0, 0);
        i_rst_n = 1'b1;
        #1 check("midrst_count", 32'(u_dut.u_id_fifo.o_count), 0);
        step();
        idle(1, 32'h5555_AAAA);
        step();
        idle(0, 0);
        #1 check("midrst_stray_err", 32'(o_err), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout reached at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

`default_nettype wire
